// File: rtl/rr_chan_mux_pkg.sv
// Shared definitions for the round-robin channel mux: arbitration mode
// encodings and the channel-index width derivation.
package rr_chan_mux_pkg;

    localparam logic RR_MODE    = 1'b0;
    localparam logic FIXED_MODE = 1'b1;

    // Index width is never narrower than one bit, even for two channels.
    function automatic int chan_w_f(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_chan_mux_rr_grant.sv
// Combinational arbiter: one-hot grant plus encoded index, round-robin from
// ptr or fixed lowest-index priority, suppressed entirely when en is low.
module rr_grant
    import rr_chan_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = chan_w_f(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CHAN_W-1:0]   ptr,
    input  logic                mode,
    input  logic                en,
    output logic [CHANNELS-1:0] grant,
    output logic [CHAN_W-1:0]   idx
);

    int                start_s;
    int                cand_s;
    logic [CHAN_W-1:0] cand_idx_s;
    logic              found_s;

    // Scan from the start index upward with wrap; first requester wins.
    always_comb begin
        grant      = '0;
        idx        = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        if (mode == FIXED_MODE) begin
            start_s = 0;
        end else begin
            start_s = int'(ptr);
        end
        if (en) begin
            for (int off = 0; off < CHANNELS; off++) begin
                cand_s = start_s + off;
                if (cand_s >= CHANNELS) begin
                    cand_s = cand_s - CHANNELS;
                end else begin
                    cand_s = cand_s;
                end
                cand_idx_s = CHAN_W'(cand_s);
                if (req[cand_idx_s] && !found_s) begin
                    found_s           = 1'b1;
                    grant[cand_idx_s] = 1'b1;
                    idx               = cand_idx_s;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

endmodule

// File: rtl/rr_chan_mux.sv
// N:1 valid/ready channel mux with a one-entry registered output buffer and
// round-robin or fixed-priority arbitration.
module rr_chan_mux
    import rr_chan_mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                prio_mode,
    input  logic [CHANNELS*WIDTH-1:0]           in_data,
    input  logic [CHANNELS-1:0]                 in_valid,
    output logic [CHANNELS-1:0]                 in_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic [chan_w_f(CHANNELS)-1:0]       out_chan,
    output logic                                out_valid,
    input  logic                                out_ready
);

    localparam int CHAN_W = chan_w_f(CHANNELS);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic                valid_q, valid_d;
    logic [CHAN_W-1:0]   ptr_q, ptr_d;
    logic                load_en_s;
    logic                grant_en_s;
    logic [CHANNELS-1:0] grant_s;
    logic [CHAN_W-1:0]   gidx_s;
    logic [WIDTH-1:0]    sel_data_s;

    // Gating with rst keeps in_ready low for the whole reset pulse.
    assign load_en_s  = !valid_q || out_ready;
    assign grant_en_s = load_en_s && !rst;

    rr_grant #(
        .CHANNELS (CHANNELS),
        .CHAN_W   (CHAN_W)
    ) u_grant (
        .req   (in_valid),
        .ptr   (ptr_q),
        .mode  (prio_mode),
        .en    (grant_en_s),
        .grant (grant_s),
        .idx   (gidx_s)
    );

    // One-hot AND-OR select of the granted channel's word.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

    // Buffer and pointer next-state: load on grant, drain on accept, else hold.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (|grant_s) begin
            data_d  = sel_data_s;
            chan_d  = gidx_s;
            valid_d = 1'b1;
            if (gidx_s == CHAN_W'(CHANNELS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx_s + CHAN_W'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign in_ready  = grant_s;
    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_chan_mux.sv
// Self-checking bench for rr_chan_mux (CHANNELS=4, WIDTH=4): directed vectors
// with literal expectations plus a per-cycle comparison against a reference model.
module tb_rr_chan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prio_mode = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic [3:0]  in_valid = 4'h0;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    rr_chan_mux #(.WIDTH(4), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .prio_mode (prio_mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: scan channel numbers in arbitration order, pick the first requester.
    function automatic logic [3:0] win(input int p, input logic [3:0] v, input logic m);
        logic [3:0] g;
        int c;
        g = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (m) c = k;
            else   c = (p + k) % 4;
            if (v[c] && g == 4'b0000) g[c] = 1'b1;
        end
        return g;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) if (g[k]) r = k;
        return r;
    endfunction

    logic       m_valid;
    logic [3:0] m_data;
    int         m_chan;
    int         m_ptr;
    logic [3:0] exp_ready;
    int         exp_k;

    always_comb begin
        if (rst) exp_ready = 4'b0000;
        else if (m_valid && !out_ready) exp_ready = 4'b0000;
        else exp_ready = win(m_ptr, in_valid, prio_mode);
        exp_k = idx_of(exp_ready);
    end

    // Model state update at each edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 4'h0;
            m_chan  <= 0;
            m_ptr   <= 0;
        end else if (exp_ready != 4'b0000) begin
            m_valid <= 1'b1;
            m_data  <= in_data[exp_k*4 +: 4];
            m_chan  <= exp_k;
            m_ptr   <= (exp_k + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare DUT against model mid-cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_in_ready", 32'(in_ready), 32'(exp_ready));
            check("mdl_out_valid", 32'(out_valid), 32'(m_valid));
            check("mdl_out_data", 32'(out_data), 32'(m_data));
            check("mdl_out_chan", 32'(out_chan), 32'(m_chan));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset state, in_ready held low even with requests
        in_valid = 4'b1111;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        cmp_en = 1'b1;

        // 2: single request on ch2
        in_valid = 4'b0100; in_data = 16'h0A00; out_ready = 1'b1; prio_mode = 1'b0;
        #2;
        check("t2_in_ready", 32'(in_ready), 32'b0100);
        step();
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data", 32'(out_data), 32'hA);
        check("t2_chan", 32'(out_chan), 32'd2);
        in_valid = 4'b1001; in_data = 16'h7005;
        #2;
        check("t2_next_ready", 32'(in_ready), 32'b1000);
        step();
        check("t2_next_chan", 32'(out_chan), 32'd3);

        // 3: reset pulse between edges, then full round-robin sweep
        in_valid = 4'b1111; in_data = 16'h4321;
        #1 rst = 1'b1;
        #1;
        check("t3_rst_valid", 32'(out_valid), 32'd0);
        check("t3_rst_data", 32'(out_data), 32'd0);
        check("t3_rst_chan", 32'(out_chan), 32'd0);
        check("t3_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_chan", 32'(out_chan), 32'(i % 4));
            check("t3_data", 32'(out_data), 32'((i % 4) + 1));
            check("t3_valid", 32'(out_valid), 32'd1);
        end

        // 4: backpressure holding ch1
        step();
        check("t4_chan", 32'(out_chan), 32'd1);
        out_ready = 1'b0;
        #2;
        check("t4_ready_blk", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_chan", 32'(out_chan), 32'd1);
            check("t4_hold_data", 32'(out_data), 32'd2);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #2;
        check("t4_release_ready", 32'(in_ready), 32'b0100);
        step();
        check("t4_release_chan", 32'(out_chan), 32'd2);
        check("t4_release_data", 32'(out_data), 32'd3);

        // 5: fixed priority, then back to round-robin
        prio_mode = 1'b1; in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_fixed_chan", 32'(out_chan), 32'd1);
        end
        prio_mode = 1'b0;
        step();
        check("t5_rr_chan_a", 32'(out_chan), 32'd3);
        step();
        check("t5_rr_chan_b", 32'(out_chan), 32'd1);

        // 6: reset mid-stream, pointer restarts at ch0
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_chan", 32'(out_chan), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; in_valid = 4'b1111; in_data = 16'h4321;
        #1;
        check("t6_first_ready", 32'(in_ready), 32'b0001);
        step();
        check("t6_first_chan", 32'(out_chan), 32'd0);
        check("t6_first_data", 32'(out_data), 32'd1);

        // idle: drain with no requests, word fields hold, pointer unchanged
        in_valid = 4'b0000;
        step();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_chan", 32'(out_chan), 32'd0);
        check("idle_data", 32'(out_data), 32'd1);
        in_valid = 4'b1111;
        step();
        check("idle_resume_chan", 32'(out_chan), 32'd1);

        // mixed traffic checked only against the model
        for (int i = 0; i < 300; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            prio_mode = ($urandom_range(0, 4) == 0);
            step();
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_chan_mux.md
Name: rr_chan_mux

Overview:
- Parametrised successor to the team's gate-level 2:1 mux: selects one of CHANNELS input channels, each WIDTH bits wide, and drives a single registered output.
- Selection is no longer a static select line: valid/ready handshakes on every input and on the output, with round-robin or fixed-priority arbitration.
- Sits between several producer blocks and one shared consumer; one-entry output buffer gives 1-cycle latency and full throughput.

Parameters:
- WIDTH, 4, data bits per channel (>=1)
- CHANNELS, 4, number of input channels (>=2)
- CHAN_W, derived = max(1, clog2(CHANNELS)), width of the channel index; not user-overridable

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept, one-hot or zero
- out_data  output  WIDTH  buffered word
- out_chan  output  CHAN_W  source channel of out_data
- out_valid  output  1  buffer holds a word
- out_ready  input  1  consumer accept

Behaviour:
- Reset (async, immediate on rst=1): out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0. A buffered word is discarded. in_ready=0 while rst=1.
- load_en = !out_valid || out_ready (combinational).
- grant (combinational) = one-hot winner among in_valid, computed only when load_en=1; otherwise all-zero.
  - Round-robin: search starts at index ptr and ascends, wrapping CHANNELS-1 -> 0.
  - Fixed priority: lowest set index wins; ptr is ignored.
- in_ready = grant. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- Transfer on channel k at an edge: out_data <= in_data[k], out_chan <= k, out_valid <= 1.
  - ptr <= k+1, wrapping to 0 when k = CHANNELS-1. The update occurs in both modes, so switching to round-robin resumes fairly.
- No transfer, but out_valid && out_ready: out_valid <= 0; out_data and out_chan hold their last values.
- out_valid && !out_ready: out_data and out_chan stable, in_ready = 0 (no overwrite).
- Throughput: one word per cycle when out_ready=1 continuously. Latency is 1 cycle from input transfer to out_valid.
- in_valid all zero: no grant, ptr unchanged.
- prio_mode may change on any cycle and takes effect combinationally on the same cycle's grant.
- in_ready must never depend on out_valid of a different cycle; no combinational path from in_valid to out_valid.
- in_ready may depend combinationally on in_valid and out_ready; consumers must not create a loop.

Decomposition:
- Shared package: the CHAN_W derivation function, and constants RR_MODE=0 and FIXED_MODE=1 for prio_mode.
- One sub-module, rr_grant: purely combinational, inputs req[CHANNELS], ptr[CHAN_W], mode, en; output one-hot grant plus encoded index.
- The top level holds the buffer registers and ptr.

Test Plan (CHANNELS=4, WIDTH=4):
1. rst=1 pulse between edges -> out_valid=0, out_data=0, out_chan=0, in_ready=0000 immediately, without waiting for clk.
2. in_valid=0100, ch2 data=4'hA, out_ready=1, rr mode -> in_ready=0100 that cycle; after the edge out_valid=1, out_data=A, out_chan=2; next arbitration starts at ch3.
3. in_valid=1111 held, data ch0..3=1,2,3,4, out_ready=1, rr mode from reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1, out_valid continuously 1.
4. Backpressure: out_valid=1 (ch1, data 2), out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000, out_data=2 and out_chan=1 stable. Then out_ready=1 -> grant ch2 that cycle, out_chan=2 after the edge.
5. prio_mode=1, in_valid=1010, out_ready=1 for 4 cycles -> out_chan=1 every cycle. Switch prio_mode=0 -> next grant ch3, then ch1.
6. rst asserted while out_valid=1 mid-stream -> out_valid drops immediately. After release with in_valid=1111, the first grant is ch0 (ptr reset).
